pic_ack_controller: RTL and testbench

Interrupt acknowledge and priority controller for the programmable interrupt controller. It synchronizes the eight IR inputs and captures them into an internal request register (edge- or level-triggered). It resolves the highest-priority unmasked request against the in-service register, raises `int_out`, and runs the two-pulse INTA sequence that moves the winner from IRR to ISR and delivers its vector. It also executes non-specific, specific and automatic EOI, with optional priority rotation.

---
 rtl/pic_ack_if.sv | 29 ++
 rtl/pic_ack_controller.sv | 172 +++++++++++++++++
 tb/tb_pic_ack_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pic_ack_if.sv
// Handshake and status bundle between the CPU-side acknowledge logic and the
// PIC acknowledge/priority controller.
interface pic_ack_if;
  logic [7:0] ir;
  logic       ltim;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       rotate;
  logic       inta;
  logic       eoi;
  logic       seoi;
  logic [2:0] seoi_level;
  logic       int_out;
  logic [7:0] vector;
  logic       vector_valid;
  logic [7:0] irr;
  logic [7:0] isr;

  modport master (
    output ir, ltim, imr, vector_base, aeoi, rotate, inta, eoi, seoi, seoi_level,
    input  int_out, vector, vector_valid, irr, isr
  );

  modport slave (
    input  ir, ltim, imr, vector_base, aeoi, rotate, inta, eoi, seoi, seoi_level,
    output int_out, vector, vector_valid, irr, isr
  );
endinterface

// File: rtl/pic_ack_controller.sv
// PIC interrupt acknowledge and priority controller: IR capture, fully nested
// priority resolution with optional rotation, two-pulse INTA and EOI handling.
module pic_ack_controller #(
  parameter int IR_SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  pic_ack_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACK2 = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [IR_SYNC_STAGES-1:0][7:0]    sync_q, sync_d;
  logic [7:0]                        prev_q, prev_d;
  logic [7:0]                        irr_q, irr_d;
  logic [7:0]                        isr_q, isr_d;
  logic                              int_out_q, int_out_d;
  logic [7:0]                        vector_q, vector_d;
  logic                              vector_valid_q, vector_valid_d;
  logic [2:0]                        lowest_q, lowest_d;
  logic [2:0]                        latched_q, latched_d;
  logic                              spurious_q, spurious_d;

  logic [7:0] sync_out_s;
  logic [2:0] start_s;
  logic       cand_v_s, isr_v_s, pend_v_s;
  logic [2:0] cand_rank_s, isr_rank_s, pend_lvl_s, isr_lvl_s;
  logic [7:0] isr_set_s, isr_clr_s, irr_clr_s;

  // Rank 0 is the highest priority; returns {found, rank of best set bit}.
  function automatic logic [3:0] prio_scan(input logic [7:0] req, input logic [2:0] start);
    logic [7:0] rot;
    logic [2:0] rank;
    logic       found;
    rot   = (req >> start) | (req << (4'd8 - {1'b0, start}));
    rank  = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        rank  = 3'(i);
        found = 1'b1;
      end
    end
    return {found, rank};
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] lvl);
    return 8'd1 << lvl;
  endfunction

  // Priority resolution against the in-service register.
  always_comb begin
    sync_out_s               = sync_q[IR_SYNC_STAGES-1];
    start_s                  = lowest_q + 3'd1;
    {cand_v_s, cand_rank_s}  = prio_scan(irr_q & ~bus.imr, start_s);
    {isr_v_s, isr_rank_s}    = prio_scan(isr_q, start_s);
    pend_v_s                 = cand_v_s && (!isr_v_s || (cand_rank_s < isr_rank_s));
    pend_lvl_s               = cand_rank_s + start_s;
    isr_lvl_s                = isr_rank_s + start_s;
  end

  // Next-state: synchronizers, INTA FSM, EOI handling, register updates.
  always_comb begin
    sync_d         = sync_q;
    prev_d         = sync_out_s;
    state_d        = state_q;
    int_out_d      = 1'b0;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    lowest_d       = lowest_q;
    latched_d      = latched_q;
    spurious_d     = spurious_q;
    isr_set_s      = 8'h00;
    isr_clr_s      = 8'h00;
    irr_clr_s      = 8'h00;

    sync_d[0] = bus.ir;
    for (int k = 1; k < IR_SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end

    case (state_q)
      IDLE: begin
        int_out_d = pend_v_s;
        if (bus.inta) begin
          state_d   = ACK2;
          int_out_d = 1'b0;
          if (pend_v_s) begin
            latched_d  = pend_lvl_s;
            spurious_d = 1'b0;
            isr_set_s  = onehot(pend_lvl_s);
            irr_clr_s  = bus.ltim ? 8'h00 : onehot(pend_lvl_s);
          end else begin
            latched_d  = 3'd7;
            spurious_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACK2: begin
        if (bus.inta) begin
          state_d        = IDLE;
          vector_d       = {bus.vector_base, latched_q};
          vector_valid_d = 1'b1;
          if (bus.aeoi && !spurious_q) begin
            isr_clr_s = onehot(latched_q);
            lowest_d  = bus.rotate ? latched_q : lowest_q;
          end else begin
            lowest_d  = lowest_q;
          end
        end else begin
          state_d = ACK2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Explicit EOI takes precedence over an automatic one for rotation.
    if (bus.seoi) begin
      isr_clr_s = isr_clr_s | onehot(bus.seoi_level);
      lowest_d  = bus.rotate ? bus.seoi_level : lowest_d;
    end else if (bus.eoi && isr_v_s) begin
      isr_clr_s = isr_clr_s | onehot(isr_lvl_s);
      lowest_d  = bus.rotate ? isr_lvl_s : lowest_d;
    end else begin
      isr_clr_s = isr_clr_s;
    end

    isr_d = (isr_q & ~isr_clr_s) | isr_set_s;
    irr_d = bus.ltim ? sync_out_s : ((irr_q & ~irr_clr_s) | (sync_out_s & ~prev_q));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sync_q         <= {IR_SYNC_STAGES{8'h00}};
      prev_q         <= 8'h00;
      irr_q          <= 8'h00;
      isr_q          <= 8'h00;
      int_out_q      <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      lowest_q       <= 3'd7;
      latched_q      <= 3'd0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      int_out_q      <= int_out_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      lowest_q       <= lowest_d;
      latched_q      <= latched_d;
      spurious_q     <= spurious_d;
    end
  end

  assign bus.int_out      = int_out_q;
  assign bus.vector       = vector_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.irr          = irr_q;
  assign bus.isr          = isr_q;

endmodule

// File: tb/tb_pic_ack_controller.sv
// Directed bench for pic_ack_controller: vectors are scoreboarded and checked
// by a monitor whenever vector_valid is seen; status is checked inline.
module tb_pic_ack_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pic_ack_if vif();

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];

  pic_ack_controller #(.IR_SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(vif));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && vif.vector_valid) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL vector_unexpected: got %h expected no vector_valid", vif.vector);
        end else begin
          logic [7:0] e;
          e = sb_q.pop_front();
          if (vif.vector !== e) begin
            n_err++;
            $display("FAIL vector: got %h expected %h", vif.vector, e);
          end
        end
      end
    end
  endtask

  task automatic wait_int();
    for (int i = 0; i < 40 && vif.int_out !== 1'b1; i++) tick(1);
    chk("int_out_rise", {7'd0, vif.int_out}, 8'h01);
  endtask

  task automatic inta_pulse();
    vif.inta = 1'b1;
    tick(1);
    vif.inta = 1'b0;
  endtask

  task automatic eoi_pulse();
    vif.eoi = 1'b1;
    tick(1);
    vif.eoi = 1'b0;
  endtask

  initial begin
    vif.ir = 8'h00; vif.ltim = 1'b0; vif.imr = 8'h00; vif.vector_base = 5'h08;
    vif.aeoi = 1'b0; vif.rotate = 1'b0; vif.inta = 1'b0; vif.eoi = 1'b0;
    vif.seoi = 1'b0; vif.seoi_level = 3'd0;
    fork monitor(); join_none
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_irr", vif.irr, 8'h00);
    chk("rst_isr", vif.isr, 8'h00);
    chk("rst_int", {7'd0, vif.int_out}, 8'h00);
    chk("rst_vec", vif.vector, 8'h00);

    // Edge mode, single IR3 pulse
    vif.ir = 8'h08;
    tick(3);
    chk("t1_irr", vif.irr, 8'h08);
    chk("t1_int_early", {7'd0, vif.int_out}, 8'h00);
    tick(1);
    chk("t1_int_rise", {7'd0, vif.int_out}, 8'h01);
    vif.ir = 8'h00;
    inta_pulse();
    chk("t1_isr", vif.isr, 8'h08);
    chk("t1_irr_clr", vif.irr, 8'h00);
    chk("t1_int_low", {7'd0, vif.int_out}, 8'h00);
    sb_q.push_back(8'h43);
    inta_pulse();
    tick(1);
    chk("t1_vec_hold", vif.vector, 8'h43);
    eoi_pulse();
    chk("t1_eoi", vif.isr, 8'h00);

    // IR5 and IR2 together, nesting
    vif.ir = 8'h24;
    wait_int();
    chk("t2_irr", vif.irr, 8'h24);
    vif.ir = 8'h00;
    inta_pulse();
    chk("t2_isr", vif.isr, 8'h04);
    chk("t2_irr_left", vif.irr, 8'h20);
    sb_q.push_back(8'h42);
    inta_pulse();
    tick(2);
    chk("t2_nested_block", {7'd0, vif.int_out}, 8'h00);
    eoi_pulse();
    chk("t2_eoi", vif.isr, 8'h00);
    tick(1);
    chk("t2_int_l5", {7'd0, vif.int_out}, 8'h01);
    inta_pulse();
    chk("t2_isr5", vif.isr, 8'h20);
    sb_q.push_back(8'h45);
    inta_pulse();
    eoi_pulse();

    // Masking
    vif.imr = 8'hFF;
    vif.ir = 8'h02;
    tick(4);
    chk("t3_irr_masked", vif.irr, 8'h02);
    chk("t3_int_masked", {7'd0, vif.int_out}, 8'h00);
    vif.imr = 8'h00;
    tick(1);
    chk("t3_int_unmask", {7'd0, vif.int_out}, 8'h01);
    vif.ir = 8'h00;
    inta_pulse();
    sb_q.push_back(8'h41);
    inta_pulse();
    eoi_pulse();

    // Spurious acknowledge in level mode
    vif.ltim = 1'b1;
    vif.ir = 8'h40;
    wait_int();
    vif.ir = 8'h00;
    tick(4);
    chk("t4_irr_drop", vif.irr, 8'h00);
    inta_pulse();
    chk("t4_isr_spur", vif.isr, 8'h00);
    sb_q.push_back(8'h47);
    inta_pulse();
    chk("t4_isr_after", vif.isr, 8'h00);

    // Rotation with automatic EOI, IR0 and IR1 held
    vif.rotate = 1'b1;
    vif.aeoi = 1'b1;
    vif.ir = 8'h03;
    wait_int();
    inta_pulse();
    chk("t5_isr0", vif.isr, 8'h01);
    sb_q.push_back(8'h40);
    inta_pulse();
    chk("t5_aeoi0", vif.isr, 8'h00);
    wait_int();
    inta_pulse();
    chk("t5_isr1_rot", vif.isr, 8'h02);
    sb_q.push_back(8'h41);
    inta_pulse();
    chk("t5_aeoi1", vif.isr, 8'h00);
    vif.seoi = 1'b1;
    vif.seoi_level = 3'd4;
    tick(1);
    vif.seoi = 1'b0;
    vif.ir = 8'h28;
    tick(4);
    chk("t5_irr28", vif.irr, 8'h28);
    wait_int();
    inta_pulse();
    chk("t5_isr5_rot4", vif.isr, 8'h20);
    sb_q.push_back(8'h45);
    inta_pulse();
    vif.ir = 8'h00;
    vif.rotate = 1'b0;
    vif.aeoi = 1'b0;
    tick(4);

    // Reset while in ACK2
    vif.ir = 8'h04;
    wait_int();
    inta_pulse();
    chk("t6_isr_pre", vif.isr, 8'h04);
    rst_n = 1'b0;
    #1;
    chk("t6_int", {7'd0, vif.int_out}, 8'h00);
    chk("t6_isr", vif.isr, 8'h00);
    chk("t6_irr", vif.irr, 8'h00);
    chk("t6_vec", vif.vector, 8'h00);
    chk("t6_vv", {7'd0, vif.vector_valid}, 8'h00);
    tick(1);
    vif.ir = 8'h00;
    rst_n = 1'b1;
    tick(6);
    chk("t6_irr_after", vif.irr, 8'h00);

    chk("sb_drain", 8'(sb_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
